// File: rtl/bitstream_feeder.sv
// CABAC bitstream byte feeder: prefetch FIFO and m_bitsNeeded tracking for regular and bypass steps.
// Optional statistics counters are enabled with the FEEDER_STATS_EN macro.
module bitstream_feeder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIN_WIDTH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rd_request,
  input  logic [7:0]        rd_data,
  input  logic              rd_ready,
  input  logic              step_valid,
  input  logic              bypass,
  input  logic [1:0]        n_bin,
  input  logic [2:0]        reg_bits,
  output logic [7:0]        byte_out,
  output logic              byte_take,
  output logic [1:0]        ep_sel,
  output logic signed [3:0] bits_needed,
  output logic              stall,
  output logic [3:0]        fifo_level
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]       bytes_consumed,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  LevelMax = 4'(FIFO_DEPTH);

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [3:0]        r_level;
  logic              r_outstanding;
  logic              r_rd_request;
  logic signed [3:0] r_bits_needed;

  logic [2:0]        w_delta;
  logic signed [4:0] w_idx;
  logic [4:0]        w_idx_sub;
  logic              w_cross;
  logic              w_push;
  logic              w_issue;

  always_comb begin
    w_delta   = bypass ? ({1'b0, n_bin} + 3'd1) : reg_bits;
    w_idx     = {r_bits_needed[3], r_bits_needed} + {2'b00, w_delta};
    w_idx_sub = w_idx - 5'd8;
    // A step reaching idx >= 0 crosses a byte boundary and needs the head byte.
    w_cross   = step_valid && !w_idx[4] && !reset;
    byte_take = w_cross && (r_level != 4'd0);
    stall     = w_cross && (r_level == 4'd0);
    // (-bits_needed)-1 is the bitwise inverse in two's complement.
    ep_sel    = (bypass && byte_take) ? ~r_bits_needed[1:0] : 2'd3;
    w_push    = rd_ready && r_outstanding;
    w_issue   = !r_outstanding && (r_level < LevelMax);
    byte_out  = (r_level == 4'd0) ? 8'h00 : r_mem[r_rptr];
  end

  assign rd_request  = r_rd_request;
  assign bits_needed = r_bits_needed;
  assign fifo_level  = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bits_needed <= 4'sb1000;
      r_level       <= 4'd0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= 1'b0;
      r_rd_request  <= 1'b0;
    end else begin
      if (byte_take) begin
        r_bits_needed <= w_idx_sub[3:0];
      end else if (step_valid && w_idx[4]) begin
        r_bits_needed <= w_idx[3:0];
      end
      if (byte_take) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      case ({w_push, byte_take})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
      r_rd_request <= w_issue;
      if (w_push) begin
        r_outstanding <= 1'b0;
      end else if (w_issue) begin
        r_outstanding <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= rd_data;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] r_bytes_consumed;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bytes_consumed <= 16'd0;
      r_stall_cycles   <= 16'd0;
    end else begin
      if (byte_take && (r_bytes_consumed != 16'hFFFF)) begin
        r_bytes_consumed <= r_bytes_consumed + 16'd1;
      end
      if (stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign bytes_consumed = r_bytes_consumed;
  assign stall_cycles   = r_stall_cycles;
`endif

  // A bypass step never carries more bins than the configured maximum.
  a_bin_range : assert property (@(posedge clk) disable iff (reset)
    (step_valid && bypass) |-> (({30'd0, n_bin} + 32'd1) <= BIN_WIDTH));

endmodule

// File: tb/tb_bitstream_feeder.sv
// Self-checking bench for bitstream_feeder: queue-based reference model, directed scenarios
// and randomized decode steps with a latency-varying reader.
module tb_bitstream_feeder;

  localparam int Depth = 4;

  logic              clk;
  logic              reset;
  logic              rd_request;
  logic [7:0]        rd_data;
  logic              rd_ready;
  logic              step_valid;
  logic              bypass;
  logic [1:0]        n_bin;
  logic [2:0]        reg_bits;
  logic [7:0]        byte_out;
  logic              byte_take;
  logic [1:0]        ep_sel;
  logic signed [3:0] bits_needed;
  logic              stall;
  logic [3:0]        fifo_level;
`ifdef FEEDER_STATS_EN
  logic [15:0]       bytes_consumed;
  logic [15:0]       stall_cycles;
`endif

  logic       rdr_ready;
  logic [7:0] rdr_data;
  logic       man_ready;
  logic [7:0] man_data;
  bit         rdr_en;
  bit         rdr_rand;

  assign rd_ready = rdr_ready | man_ready;
  assign rd_data  = man_ready ? man_data : rdr_data;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_hist[$];
  int         m_bn;
  bit         m_out;
  bit         m_req;
  int         m_cons;
  int         m_stallc;

  bitstream_feeder #(
    .FIFO_DEPTH(Depth),
    .BIN_WIDTH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_request (rd_request),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .step_valid (step_valid),
    .bypass     (bypass),
    .n_bin      (n_bin),
    .reg_bits   (reg_bits),
    .byte_out   (byte_out),
    .byte_take  (byte_take),
    .ep_sel     (ep_sel),
    .bits_needed(bits_needed),
    .stall      (stall),
    .fifo_level (fifo_level)
`ifdef FEEDER_STATS_EN
    ,
    .bytes_consumed(bytes_consumed),
    .stall_cycles  (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_bn     = -8;
    m_out    = 1'b0;
    m_req    = 1'b0;
    m_cons   = 0;
    m_stallc = 0;
  endfunction

  // Model: expected outputs mid-cycle, state advanced at each rising edge
  initial begin
    int delta, idx, old_size;
    bit take, stl, old_out;
    m_reset();
    forever begin
      @(negedge clk);
      if (reset) m_reset();
      delta = bypass ? int'(n_bin) + 1 : int'(reg_bits);
      idx   = m_bn + delta;
      take  = !reset && step_valid && idx >= 0 && m_q.size() > 0;
      stl   = !reset && step_valid && idx >= 0 && m_q.size() == 0;
      chk("rd_request", int'(rd_request), int'(m_req));
      chk("byte_out", int'(byte_out), (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("byte_take", int'(byte_take), int'(take));
      chk("stall", int'(stall), int'(stl));
      chk("ep_sel", int'(ep_sel), (bypass && take) ? -m_bn - 1 : 3);
      chk("bits_needed", int'(bits_needed), m_bn);
      chk("fifo_level", int'(fifo_level), m_q.size());
`ifdef FEEDER_STATS_EN
      chk("bytes_consumed", int'(bytes_consumed), m_cons);
      chk("stall_cycles", int'(stall_cycles), m_stallc);
`endif
      @(posedge clk);
      if (!reset) begin
        old_size = m_q.size();
        old_out  = m_out;
        if (take) begin
          void'(m_q.pop_front());
          m_bn = idx - 8;
          if (m_cons < 65535) m_cons++;
        end else if (step_valid && idx < 0) begin
          m_bn = idx;
        end
        if (stl && m_stallc < 65535) m_stallc++;
        if (rd_ready && old_out) begin
          m_q.push_back(rd_data);
          m_hist.push_back(rd_data);
          m_out = 1'b0;
        end
        m_req = !old_out && (old_size + 1 <= Depth);
        if (m_req) m_out = 1'b1;
      end
    end
  end

  // File reader: answers each request after a fixed or random latency
  initial begin
    int lat;
    rdr_ready = 1'b0;
    rdr_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_request && rdr_en && !reset) begin
        lat = rdr_rand ? int'($urandom_range(1, 3)) : 2;
        repeat (lat) @(posedge clk);
        #1;
        rdr_ready = 1'b1;
        rdr_data  = 8'($urandom);
        @(posedge clk);
        #1 rdr_ready = 1'b0;
      end
    end
  end

  task automatic drive(input bit sv, input bit byp, input int nb, input int rb);
    @(posedge clk);
    #1;
    step_valid = sv;
    bypass     = byp;
    n_bin      = 2'(nb);
    reg_bits   = 3'(rb);
  endtask

  task automatic answer(input logic [7:0] d);
    for (int i = 0; i < 10 && !m_out; i++) @(negedge clk);
    chk("read_outstanding", int'(m_out), 1);
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    man_data  = d;
    @(posedge clk);
    #1 man_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b[3];
    reset      = 1'b1;
    step_valid = 1'b0;
    bypass     = 1'b0;
    n_bin      = 2'd0;
    reg_bits   = 3'd0;
    man_ready  = 1'b0;
    man_data   = 8'h00;
    rdr_en     = 1'b1;
    rdr_rand   = 1'b0;
    n_checks   = 0;
    n_fail     = 0;

    // Reset state and first request
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bits_needed", int'(bits_needed), -8);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_rd_request", int'(rd_request), 0);
    chk("rst_ep_sel", int'(ep_sel), 3);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rd_request_before_edge", int'(rd_request), 0);
    @(posedge clk);
    #1 chk("first_rd_request", int'(rd_request), 1);

    // Fill to depth, then requests stop
    repeat (24) @(posedge clk);
    @(negedge clk);
    chk("fill_level", int'(fifo_level), 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_request", int'(rd_request), 0);
    end

    // Bypass steps of 3 bins from -8
    drive(1, 1, 2, 0);
    @(negedge clk);
    chk("byp1_take", int'(byte_take), 0);
    drive(1, 1, 2, 0);
    @(negedge clk);
    chk("byp2_bits", int'(bits_needed), -5);
    drive(1, 1, 2, 0);
    @(negedge clk);
    chk("byp3_bits", int'(bits_needed), -2);
    chk("byp3_take", int'(byte_take), 1);
    chk("byp3_ep_sel", int'(ep_sel), 1);
    chk("byp3_first_byte", int'(byte_out), int'(m_hist[0]));
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("byp_after_bits", int'(bits_needed), -7);
    chk("model_bits", m_bn, -7);

    // Regular steps
    drive(1, 0, 0, 7);
    @(negedge clk);
    chk("reg_align_take", int'(byte_take), 1);
    chk("reg_align_ep", int'(ep_sel), 3);
    drive(1, 0, 0, 7);
    @(negedge clk);
    chk("reg7_take", int'(byte_take), 0);
    drive(1, 0, 0, 1);
    @(negedge clk);
    chk("reg1_bits", int'(bits_needed), -1);
    chk("reg1_take", int'(byte_take), 1);
    chk("reg1_ep", int'(ep_sel), 3);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("reg_after_bits", int'(bits_needed), -8);

    // Drain with the reader silent, then stall on an empty FIFO
    rdr_en = 1'b0;
    repeat (8) drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_level == 4'd0) break;
      drive(1, 0, 0, 7);
      drive(1, 0, 0, 1);
      drive(0, 0, 0, 0);
    end
    @(negedge clk);
    chk("drained_level", int'(fifo_level), 0);
    drive(1, 0, 0, 7);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("empty_stall", int'(stall), 1);
    chk("empty_bits", int'(bits_needed), -1);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("empty_stall_held", int'(stall), 1);
    chk("empty_bits_held", int'(bits_needed), -1);
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    man_data  = 8'hA5;
    @(negedge clk);
    chk("arrival_cycle_stall", int'(stall), 1);
    @(posedge clk);
    #1 man_ready = 1'b0;
    @(negedge clk);
    chk("arrival_next_take", int'(byte_take), 1);
    chk("arrival_byte", int'(byte_out), 8'hA5);
    chk("arrival_ep", int'(ep_sel), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("arrival_after_bits", int'(bits_needed), -8);

    // Simultaneous push and pop at level 3
    answer(8'hB1);
    answer(8'hB2);
    answer(8'hB3);
    drive(1, 0, 0, 7);
    @(posedge clk);
    #1;
    man_ready  = 1'b1;
    man_data   = 8'hB4;
    step_valid = 1'b1;
    bypass     = 1'b0;
    reg_bits   = 3'd1;
    @(negedge clk);
    chk("pp_level_before", int'(fifo_level), 3);
    chk("pp_take", int'(byte_take), 1);
    chk("pp_head", int'(byte_out), 8'hB1);
    @(posedge clk);
    #1;
    man_ready  = 1'b0;
    step_valid = 1'b0;
    @(negedge clk);
    chk("pp_level_after", int'(fifo_level), 3);
    exp_b[0] = 8'hB2;
    exp_b[1] = 8'hB3;
    exp_b[2] = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 7);
      drive(1, 0, 0, 1);
      @(negedge clk);
      chk("order_take", int'(byte_take), 1);
      chk("order_byte", int'(byte_out), int'(exp_b[i]));
    end
    drive(0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Reset with a read outstanding, then a stray rd_ready
    chk("pre_reset_outstanding", int'(m_out), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    man_ready = 1'b1;
    man_data  = 8'h5A;
    @(negedge clk);
    chk("stray_level", int'(fifo_level), 0);
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    rdr_en    = 1'b1;
    chk("post_reset_request", int'(rd_request), 1);
    @(negedge clk);
    chk("stray_ignored_level", int'(fifo_level), 0);

    // Randomized decode steps with random reader latency and rare resets
    rdr_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk);
        #1;
        reset      = 1'b1;
        step_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 7)));
      end
    end
    drive(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_feeder.md
BITSTREAM_FEEDER -- requirements
Module: bitstream_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of prefetched bitstream bytes held (power of two, 2..8).
REQ-002 SHALL have parameter BIN_WIDTH, default 3, meaning the maximum bypass bins consumed per step.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rd_request  output  1  one-cycle byte request pulse to the file reader.
REQ-006 SHALL have port rd_data  input  8  byte returned by the reader.
REQ-007 SHALL have port rd_ready  input  1  rd_data valid this cycle.
REQ-008 SHALL have port step_valid  input  1  decoder performs one decode step this cycle.
REQ-009 SHALL have port bypass  input  1  step is bypass (1) or regular (0).
REQ-010 SHALL have port n_bin  input  2  bypass bins in step minus one.
REQ-011 SHALL have port reg_bits  input  3  renormalisation bits consumed by a regular step (0..7).
REQ-012 SHALL have port byte_out  output  8  FIFO head byte, for merging into m_value.
REQ-013 SHALL have port byte_take  output  1  step crosses a byte boundary; byte_out is consumed this cycle.
REQ-014 SHALL have port ep_sel  output  2  EP lane receiving the byte (0..2); 3 = regular lane.
REQ-015 SHALL have port bits_needed  output  4 signed  current m_bitsNeeded.
REQ-016 SHALL have port stall  output  1  step needs a byte but the FIFO is empty.
REQ-017 SHALL have port fifo_level  output  4  number of bytes held.

Function
REQ-018 SHALL compute delta = n_bin+1 when bypass, else reg_bits, and idx = bits_needed + delta as a 5-bit signed sum.
REQ-019 SHALL assert byte_take combinationally when step_valid and idx >= 0 and fifo_level > 0.
REQ-020 SHALL assert stall combinationally when step_valid and idx >= 0 and fifo_level == 0; the step is then ignored and bits_needed is held.
REQ-021 SHALL update bits_needed to idx-8 on byte_take, to idx on step_valid with idx < 0, and hold it otherwise.
REQ-022 SHALL drive ep_sel = (-bits_needed)-1 when bypass and byte_take, else 3.
REQ-023 SHALL pop the FIFO head on byte_take, with the next head visible on byte_out the following cycle.
REQ-024 SHALL keep at most one read outstanding and pulse rd_request for one cycle when no read is outstanding and fifo_level+1 <= FIFO_DEPTH.
REQ-025 SHALL push rd_data on rd_ready only while a read is outstanding, clearing the outstanding flag; rd_ready with nothing outstanding is ignored.
REQ-026 SHALL leave fifo_level unchanged on a simultaneous push and pop, and SHALL use wrap-around read and write pointers of log2(FIFO_DEPTH) bits.
REQ-027 SHALL drive byte_out to 0 when the FIFO is empty.
REQ-028 SHALL keep a step accepted in the same cycle as rd_ready on an empty FIFO stalled; the pushed byte is first usable the following cycle.

Reset
REQ-029 SHALL on reset set bits_needed = -8, fifo_level = 0, pointers = 0, and the outstanding flag = 0.
REQ-030 SHALL on reset drive rd_request = 0, byte_take = 0, stall = 0, and ep_sel = 3.
REQ-031 SHALL discard any read in flight when reset asserts mid-operation; a late rd_ready after release is ignored.
REQ-032 SHALL issue the first rd_request on the first clock edge after reset release.

Configuration
REQ-033 SHALL, with FEEDER_STATS_EN defined, add outputs bytes_consumed (16 bits, counts byte_take) and stall_cycles (16 bits, counts stall), both saturating at 0xFFFF and reset to 0.
REQ-034 SHALL, without FEEDER_STATS_EN, omit those ports and counters, with all other behaviour identical.

Verification
REQ-035 SHALL cover: after reset, reader answers each request in 2 cycles -> fifo_level reaches 4, then rd_request stays 0.
REQ-036 SHALL cover: full FIFO, bits_needed=-8, bypass steps with n_bin=2 ×3 -> bits_needed -5, -2, then byte_take with ep_sel=1 and bits_needed=-7.
REQ-037 SHALL cover: regular step with reg_bits=7 from -8, then reg_bits=1 -> bits_needed -1, then byte_take with ep_sel=3 and bits_needed=-8.
REQ-038 SHALL cover: empty FIFO, bits_needed=-1, bypass step -> stall=1 and bits_needed held; after the byte arrives -> byte_take next cycle.
REQ-039 SHALL cover: pop and rd_ready in the same cycle at level 3 -> level stays 3 and byte order is preserved across pointer wrap.
REQ-040 SHALL cover: reset asserted with a read outstanding, then a stray rd_ready -> fifo_level stays 0.
